// File: rtl/bcd_countdown2.sv
// Two-digit BCD down-counter with load, pause, borrow pulse and optional
// auto-reload of the last loaded value on expiry.
//
// state   | meaning
// IDLE    | after reset; waits for load, en ignored
// RUN     | counting down one step per cycle while en is high
// EXPIRED | reached 00 and borrowed with WRAP=0; waits for load
module bcd_countdown2 #(
  parameter bit         WRAP              = 1'b0,
  parameter logic [3:0] LOAD_DEFAULT_TENS = 4'h5,
  parameter logic [3:0] LOAD_DEFAULT_ONES = 4'h9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       borrow,
  output logic       zero,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  state_t     state;
  logic [3:0] shadow_tens;
  logic [3:0] shadow_ones;
  logic [3:0] clamp_tens;
  logic [3:0] clamp_ones;

  // Out-of-range load digits saturate to 9 so the digits always stay BCD.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign clamp_tens = bcd_clamp(load_tens);
  assign clamp_ones = bcd_clamp(load_ones);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      tens        <= 4'd0;
      ones        <= 4'd0;
      shadow_tens <= bcd_clamp(LOAD_DEFAULT_TENS);
      shadow_ones <= bcd_clamp(LOAD_DEFAULT_ONES);
      borrow      <= 1'b0;
    end else begin
      borrow <= 1'b0;
      if (load) begin
        // A load takes priority over en; no step happens on a load cycle.
        tens        <= clamp_tens;
        ones        <= clamp_ones;
        shadow_tens <= clamp_tens;
        shadow_ones <= clamp_ones;
        state       <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (en) begin
              if (ones != 4'd0) begin
                ones <= ones - 4'd1;
              end else if (tens != 4'd0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
              end else begin
                borrow <= 1'b1;
                if (WRAP) begin
                  tens <= shadow_tens;
                  ones <= shadow_ones;
                end else begin
                  state <= EXPIRED;
                end
              end
            end
          end
          IDLE, EXPIRED: begin
            state <= state;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign zero = (tens == 4'd0) && (ones == 4'd0);
  assign busy = (state == RUN);

endmodule

// File: tb/tb_bcd_countdown2.sv
// Directed bench for bcd_countdown2: one instance with WRAP=0 and one with
// WRAP=1 share the same stimulus; outputs are checked #1 after each edge.
module tb_bcd_countdown2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       en = 1'b0;

  logic [3:0] tens, ones;
  logic       borrow, zero, busy;
  logic [3:0] w_tens, w_ones;
  logic       w_borrow, w_zero, w_busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bcd_countdown2 #(.WRAP(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .en(en), .tens(tens), .ones(ones),
    .borrow(borrow), .zero(zero), .busy(busy)
  );

  bcd_countdown2 #(.WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .en(en), .tens(w_tens), .ones(w_ones),
    .borrow(w_borrow), .zero(w_zero), .busy(w_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] lt,
                       input logic [3:0] lo, input logic e);
    rst = r; load = l; load_tens = lt; load_ones = lo; en = e;
  endtask

  // {tens, ones, borrow, zero, busy}
  task automatic test_reset();
    drive(1'b0, 1'b1, 4'd7, 4'd7, 1'b1);
    tick();
    vectors++;
    if ({tens, ones, borrow, zero, busy} !== {4'd0, 4'd0, 3'b010}) begin
      errors++;
      $display("FAIL reset: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 0 0 0 1 0",
               tens, ones, borrow, zero, busy);
    end
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({tens, ones, borrow, zero, busy} !== {4'd0, 4'd0, 3'b010}) begin
        errors++;
        $display("FAIL idle_ignores_en[%0d]: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 0 0 0 1 0",
                 i, tens, ones, borrow, zero, busy);
      end
    end
  endtask

  task automatic test_count();
    int v;
    drive(1'b1, 1'b1, 4'd2, 4'd3, 1'b0);
    tick();
    vectors++;
    if ({tens, ones, borrow, zero, busy} !== {4'd2, 4'd3, 3'b001}) begin
      errors++;
      $display("FAIL count_load: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 2 3 0 0 1",
               tens, ones, borrow, zero, busy);
    end
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 1; i <= 23; i++) begin
      tick();
      v = 23 - i;
      vectors++;
      if (tens !== 4'(v / 10) || ones !== 4'(v % 10) || borrow !== 1'b0 ||
          zero !== (v == 0) || busy !== 1'b1) begin
        errors++;
        $display("FAIL count_step[%0d]: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want %0d %0d 0 %0b 1",
                 i, tens, ones, borrow, zero, busy, v / 10, v % 10, (v == 0));
      end
    end
    tick();
    vectors++;
    if ({tens, ones, borrow, zero, busy} !== {4'd0, 4'd0, 3'b110}) begin
      errors++;
      $display("FAIL count_borrow: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 0 0 1 1 0",
               tens, ones, borrow, zero, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({tens, ones, borrow, zero, busy} !== {4'd0, 4'd0, 3'b010}) begin
        errors++;
        $display("FAIL expired_hold[%0d]: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 0 0 0 1 0",
                 i, tens, ones, borrow, zero, busy);
      end
    end
  endtask

  task automatic test_clamp();
    drive(1'b1, 1'b1, 4'hA, 4'hF, 1'b0);
    tick();
    vectors++;
    if ({tens, ones, busy} !== {4'd9, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL clamp_load: got t=%0d o=%0d busy=%0b, want 9 9 1", tens, ones, busy);
    end
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    vectors++;
    if ({tens, ones, borrow} !== {4'd9, 4'd8, 1'b0}) begin
      errors++;
      $display("FAIL clamp_dec: got t=%0d o=%0d b=%0b, want 9 8 0", tens, ones, borrow);
    end
    drive(1'b1, 1'b1, 4'd3, 4'hC, 1'b0);
    tick();
    vectors++;
    if ({tens, ones} !== {4'd3, 4'd9}) begin
      errors++;
      $display("FAIL clamp_ones: got t=%0d o=%0d, want 3 9", tens, ones);
    end
  endtask

  task automatic test_load_en();
    drive(1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'd3, 4'd0, 1'b1);
    tick();
    vectors++;
    if ({tens, ones, borrow, busy} !== {4'd3, 4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL load_with_en: got t=%0d o=%0d b=%0b busy=%0b, want 3 0 0 1",
               tens, ones, borrow, busy);
    end
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    vectors++;
    if ({tens, ones} !== {4'd2, 4'd9}) begin
      errors++;
      $display("FAIL load_with_en_next: got t=%0d o=%0d, want 2 9", tens, ones);
    end
  endtask

  task automatic test_pause();
    drive(1'b1, 1'b1, 4'd4, 4'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({tens, ones, borrow, busy} !== {4'd4, 4'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL pause[%0d]: got t=%0d o=%0d b=%0b busy=%0b, want 4 0 0 1",
                 i, tens, ones, borrow, busy);
      end
    end
    en = 1'b1;
    tick();
    vectors++;
    if ({tens, ones} !== {4'd3, 4'd9}) begin
      errors++;
      $display("FAIL pause_resume: got t=%0d o=%0d, want 3 9", tens, ones);
    end
  endtask

  task automatic test_zero_load();
    drive(1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    tick();
    vectors++;
    if ({tens, ones, borrow, zero, busy} !== {4'd0, 4'd0, 3'b011}) begin
      errors++;
      $display("FAIL zero_load: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 0 0 0 1 1",
               tens, ones, borrow, zero, busy);
    end
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    vectors++;
    if ({tens, ones, borrow, zero, busy} !== {4'd0, 4'd0, 3'b110}) begin
      errors++;
      $display("FAIL zero_load_borrow: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 0 0 1 1 0",
               tens, ones, borrow, zero, busy);
    end
    vectors++;
    if ({w_tens, w_ones, w_borrow, w_busy} !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_zero_load_borrow: got t=%0d o=%0d b=%0b busy=%0b, want 0 0 1 1",
               w_tens, w_ones, w_borrow, w_busy);
    end
  endtask

  task automatic test_reset_abort();
    drive(1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    vectors++;
    if ({tens, ones, borrow, zero, busy} !== {4'd0, 4'd0, 3'b010}) begin
      errors++;
      $display("FAIL reset_abort: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 0 0 0 1 0",
               tens, ones, borrow, zero, busy);
    end
    vectors++;
    if ({w_borrow, w_busy} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_reset_abort: got b=%0b busy=%0b, want 0 0", w_borrow, w_busy);
    end
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({tens, ones, borrow, busy, w_borrow, w_busy} !== {4'd0, 4'd0, 4'b0000}) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: got t=%0d o=%0d b=%0b busy=%0b wb=%0b wbusy=%0b, want 0 0 0 0 0 0",
                 i, tens, ones, borrow, busy, w_borrow, w_busy);
      end
    end
    drive(1'b1, 1'b1, 4'd1, 4'd2, 1'b0);
    tick();
    vectors++;
    if ({tens, ones, busy} !== {4'd1, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_load: got t=%0d o=%0d busy=%0b, want 1 2 1", tens, ones, busy);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_o;
    logic       exp_b;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
    tick();
    vectors++;
    if ({w_tens, w_ones, w_busy} !== {4'd0, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_load: got t=%0d o=%0d busy=%0b, want 0 1 1", w_tens, w_ones, w_busy);
    end
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_o = (i % 2 == 1) ? 4'd0 : 4'd1;
      exp_b = (i % 2 == 0);
      vectors++;
      if ({w_tens, w_ones, w_borrow, w_zero, w_busy} !==
          {4'd0, exp_o, exp_b, (exp_o == 4'd0), 1'b1}) begin
        errors++;
        $display("FAIL wrap_step[%0d]: got t=%0d o=%0d b=%0b z=%0b busy=%0b, want 0 %0d %0b %0b 1",
                 i, w_tens, w_ones, w_borrow, w_zero, w_busy, exp_o, exp_b, (exp_o == 4'd0));
      end
    end
    en = 1'b0;
    tick();
    vectors++;
    if ({w_borrow, w_busy} !== 2'b01) begin
      errors++;
      $display("FAIL wrap_borrow_clear: got b=%0b busy=%0b, want 0 1", w_borrow, w_busy);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_clamp();
    test_load_en();
    test_pause();
    test_zero_load();
    test_reset_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
